spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl_pkg.sv | 16 +
 rtl/spi_master_ctrl_clkdiv.sv | 29 ++
 rtl/spi_master_ctrl.sv | 144 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_ctrl_pkg.sv
// Shared types and widths for the SPI master controller.
package spi_master_ctrl_pkg;

  localparam int BYTE_W    = 8;
  localparam int DIV_W     = 8;
  localparam int BIT_CNT_W = $clog2(BYTE_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    HOLD,
    GAP
  } state_t;

endpackage

// File: rtl/spi_master_ctrl_clkdiv.sv
// Half-period phase counter: one-cycle tick every CLK_DIV clk cycles, re-phased by clear.
module spi_master_ctrl_clkdiv
  import spi_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: byte command/response streams, CS framing via cmd_last.
// Optional loopback self-check enabled by defining SPI_MASTER_CTRL_LOOPCHECK_EN.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [BYTE_W-1:0] cmd_data,
  input  logic              cmd_last,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BYTE_W-1:0] rsp_data,
  output logic              busy,
  output logic              loop_err,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CS_n
);

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  state_t               state;
  logic [BYTE_W-1:0]    tx_sh;
  logic [BYTE_W-1:0]    rx_sh;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 last_q;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 tick;
  logic                 accept;
  logic                 done;

  assign cmd_ready = !rst && ((state == IDLE) || (state == HOLD)) && (!rsp_valid || rsp_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  // Byte ends one full low phase after the eighth falling edge.
  assign done      = (state == SHIFT) && tick && !SCK && (bit_cnt == BIT_CNT_W'(BYTE_W));

  spi_master_ctrl_clkdiv #(
    .CLK_DIV(CLK_DIV)
  ) u_clkdiv (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      CS_n      <= 1'b1;
      SCK       <= 1'b0;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            state   <= LEAD;
            CS_n    <= 1'b0;
            MOSI    <= cmd_data[BYTE_W-1];
            tx_sh   <= cmd_data;
            last_q  <= cmd_last;
            bit_cnt <= '0;
          end
        end
        LEAD: begin
          if (tick) begin
            SCK   <= 1'b1;
            rx_sh <= {rx_sh[BYTE_W-2:0], MISO};
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (SCK) begin
              SCK     <= 1'b0;
              MOSI    <= tx_sh[BYTE_W-2];
              tx_sh   <= {tx_sh[BYTE_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end else if (done) begin
              rsp_valid <= 1'b1;
              rsp_data  <= rx_sh;
              gap_cnt   <= '0;
              if (last_q) begin
                CS_n  <= 1'b1;
                state <= GAP;
              end else begin
                state <= HOLD;
              end
            end else begin
              SCK   <= 1'b1;
              rx_sh <= {rx_sh[BYTE_W-2:0], MISO};
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_CTRL_LOOPCHECK_EN
  // A 1-bit-delay loopback returns the previous byte's LSB followed by tx[7:1].
  logic [BYTE_W-1:0] tx_byte;
  logic              prev_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_bit <= 1'b1;
      loop_err <= 1'b0;
    end else begin
      if (accept) begin
        tx_byte <= cmd_data;
      end
      if (done) begin
        if (rx_sh != {prev_bit, tx_byte[BYTE_W-1:1]}) begin
          loop_err <= 1'b1;
        end
        prev_bit <= tx_byte[0];
      end
    end
  end
`else
  assign loop_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: loopback slave, timing model and directed scenarios.
module tb_spi_master_ctrl;

  localparam int D = 2;
  localparam int G = 2;
`ifdef SPI_MASTER_CTRL_LOOPCHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    int         due;
    bit         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  logic       cmd_valid = 1'b0, cmd_last = 1'b0, rsp_ready = 1'b1;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, rsp_valid, busy, loop_err, SCK, MOSI, MISO, CS_n;
  logic [7:0] rsp_data;

  logic       cmd_valid1 = 1'b0, cmd_last1 = 1'b0, rsp_ready1 = 1'b1;
  logic [7:0] cmd_data1 = 8'h00;
  logic       cmd_ready1, rsp_valid1, busy1, loop_err1, SCK1, MOSI1, MISO1, CS_n1;
  logic [7:0] rsp_data1;

  logic q0, q1, sck0_d, sck1_d;
  bit   force0 = 1'b0;

  exp_t       exp_q[$];
  int         byte_t = -1;
  logic [7:0] byte_tx = 8'h00;
  bit         byte_last = 1'b0;
  bit         loop_sticky = 1'b0;
  bit         prev_tx0 = 1'b1;

  spi_master_ctrl #(.CLK_DIV(D), .CS_GAP(G)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_last(cmd_last), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy), .loop_err(loop_err),
    .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .CS_n(CS_n)
  );

  spi_master_ctrl #(.CLK_DIV(1), .CS_GAP(G)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_data(cmd_data1), .cmd_last(cmd_last1), .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .busy(busy1), .loop_err(loop_err1),
    .SCK(SCK1), .MOSI(MOSI1), .MISO(MISO1), .CS_n(CS_n1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Loopback slaves: capture MOSI on each SCK rise, present it back on MISO.
  always @(posedge clk) begin
    sck0_d <= SCK;
    sck1_d <= SCK1;
    if (rst) begin
      q0 <= 1'b1;
      q1 <= 1'b1;
    end else begin
      if (SCK && !sck0_d) q0 <= MOSI;
      if (SCK1 && !sck1_d) q1 <= MOSI1;
    end
  end
  assign MISO  = force0 ? 1'b0 : q0;
  assign MISO1 = q1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: SCK/MOSI/CS_n/busy derived from offset into the current byte.
  always @(negedge clk) begin : cmp
    int o;
    int ph;
    bit e_cs, e_sck, e_busy;
    if (byte_t < 0) begin
      e_cs = 1'b1; e_sck = 1'b0; e_busy = 1'b0;
    end else begin
      o = cyc - byte_t - 1;
      if (o < 17 * D) begin
        ph = o / D;
        e_cs = 1'b0; e_sck = (ph % 2) == 1; e_busy = 1'b1;
        if (ph <= 15) chk("mosi", 32'(MOSI), 32'(byte_tx[7 - ph / 2]));
      end else begin
        e_cs = byte_last; e_sck = 1'b0;
        e_busy = !byte_last || (o < 17 * D + G);
      end
    end
    chk("cs_n", 32'(CS_n), 32'(e_cs));
    chk("sck", 32'(SCK), 32'(e_sck));
    chk("busy", 32'(busy), 32'(e_busy));
    if (exp_q.size() == 0) begin
      chk("rsp_spurious", 32'(rsp_valid), 0);
    end else begin
      if (cyc == exp_q[0].due) begin
        if (exp_q[0].err && LC) loop_sticky = 1'b1;
        chk("rsp_on_time", 32'(rsp_valid), 1);
      end
      if (rsp_valid) begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
        if (cyc < exp_q[0].due) chk("rsp_early", cyc, exp_q[0].due);
      end
    end
    chk("loop_err", 32'(loop_err), 32'(loop_sticky));
    #2;
    if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  task automatic do_reset();
    #1;
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid1 = 1'b0;
    byte_t = -1; exp_q.delete(); loop_sticky = 1'b0; prev_tx0 = 1'b1;
    @(negedge clk);
    chk("rst_cs_n", 32'(CS_n), 1);
    chk("rst_sck", 32'(SCK), 0);
    chk("rst_mosi", 32'(MOSI), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_loop_err", 32'(loop_err), 0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last, output int t);
    int   n;
    exp_t e;
    n = 0;
    #1;
    cmd_valid = 1'b1; cmd_data = d; cmd_last = last;
    while (!cmd_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept", 32'(cmd_ready), 1);
      cmd_valid = 1'b0; t = -1;
      return;
    end
    t = cyc;
    e.data = force0 ? 8'h00 : {prev_tx0, d[7:1]};
    e.due  = t + 1 + 17 * D;
    e.err  = (e.data != {prev_tx0, d[7:1]});
    prev_tx0 = d[0];
    @(posedge clk);
    exp_q.push_back(e);
    byte_t = t; byte_tx = d; byte_last = last;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int t, output logic [7:0] d);
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!rsp_valid && n < 200);
    if (!rsp_valid) chk("rsp_wait", 32'(rsp_valid), 1);
    t = cyc; d = rsp_data;
  endtask

  initial begin
    int t, t2, tr, t1, tb2, nr;
    logic [7:0] d;
    bit acc;
    do_reset();

    // Single byte with CS release and gap.
    send(8'hA5, 1'b1, t);
    wait_rsp(tr, d);
    chk("single_time", tr, t + 35);
    chk("single_data", 32'(d), 32'hD2);
    chk("single_cs_high0", 32'(CS_n), 1);
    @(negedge clk);
    chk("single_cs_high1", 32'(CS_n), 1);
    chk("single_busy_gap", 32'(busy), 1);
    @(negedge clk);
    chk("single_busy_idle", 32'(busy), 0);
    chk("single_loop_err", 32'(loop_err), 0);

    // Two bytes in one frame.
    do_reset();
    send(8'hA5, 1'b0, t);
    wait_rsp(tr, d);
    chk("pair0_time", tr, t + 35);
    chk("pair0_data", 32'(d), 32'hD2);
    send(8'h3C, 1'b1, t2);
    chk("pair_hold_accept", t2, t + 35);
    wait_rsp(tr, d);
    chk("pair1_time", tr, t2 + 35);
    chk("pair1_data", 32'(d), 32'h9E);

    // Response back-pressure stalls the next command.
    do_reset();
    rsp_ready = 1'b0;
    send(8'hA5, 1'b0, t);
    wait_rsp(tr, d);
    chk("bp_data0", 32'(d), 32'hD2);
    #1;
    cmd_valid = 1'b1; cmd_data = 8'h3C; cmd_last = 1'b1;
    repeat (5) begin
      chk("bp_stall", 32'(cmd_ready), 0);
      @(negedge clk); #1;
    end
    chk("bp_rsp_held", 32'(rsp_data), 32'hD2);
    rsp_ready = 1'b1;
    send(8'h3C, 1'b1, t2);
    wait_rsp(tr, d);
    chk("bp_time1", tr, t2 + 35);
    chk("bp_data1", 32'(d), 32'h9E);

    // Reset during a byte aborts it.
    do_reset();
    send(8'h5A, 1'b1, t);
    repeat (9 * D + 1) @(negedge clk);
    chk("abort_sck_high", 32'(SCK), 1);
    chk("abort_cs_low", 32'(CS_n), 0);
    do_reset();
    send(8'hFF, 1'b1, t);
    wait_rsp(tr, d);
    chk("post_abort_time", tr, t + 35);
    chk("post_abort_data", 32'(d), 32'hFF);

    // Stuck-low MISO.
    do_reset();
    force0 = 1'b1;
    send(8'hFF, 1'b1, t);
    wait_rsp(tr, d);
    chk("stuck_data", 32'(d), 32'h00);
    chk("stuck_loop_err", 32'(loop_err), 32'(LC));
    repeat (4) @(negedge clk);
    chk("stuck_loop_sticky", 32'(loop_err), 32'(LC));
    force0 = 1'b0;
    do_reset();

    // CLK_DIV=1 instance, back-to-back 0x00 then 0xFF.
    t1 = -1; tb2 = -1; nr = 0;
    #1;
    cmd_valid1 = 1'b1; cmd_data1 = 8'h00; cmd_last1 = 1'b0;
    for (int k = 0; k < 60; k++) begin
      acc = cmd_valid1 && cmd_ready1;
      if (acc) begin
        if (t1 < 0) t1 = cyc;
        else tb2 = cyc;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (tb2 < 0) begin
          cmd_data1 = 8'hFF; cmd_last1 = 1'b1;
        end else begin
          cmd_valid1 = 1'b0;
        end
      end
      @(negedge clk);
      if (t1 >= 0) begin
        if (cyc == t1 + 2) chk("div1_sck_t2", 32'(SCK1), 1);
        if (cyc == t1 + 3) chk("div1_sck_t3", 32'(SCK1), 0);
        if (cyc == t1 + 4) chk("div1_sck_t4", 32'(SCK1), 1);
        if (cyc > t1 && (tb2 < 0 || cyc < tb2 + 18)) chk("div1_cs_low", 32'(CS_n1), 0);
        if (tb2 >= 0 && cyc == tb2 + 18) chk("div1_cs_release", 32'(CS_n1), 1);
      end
      if (rsp_valid1) begin
        if (nr == 0) begin
          chk("div1_rsp0_time", cyc, t1 + 18);
          chk("div1_rsp0_data", 32'(rsp_data1), 32'h80);
        end else begin
          chk("div1_rsp1_time", cyc, tb2 + 18);
          chk("div1_rsp1_data", 32'(rsp_data1), 32'h7F);
        end
        nr++;
      end
      #1;
    end
    chk("div1_rsp_count", nr, 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
